tmds_multich_encoder: RTL and testbench
=======================================

// Module: tmds_multich_encoder
// PURPOSE
//  Parametrised NUM_CH-lane TMDS encoder for DVI/HDMI transmit.
//  - Adds TERC4 data-island coding and video/data-island guard bands to the
//    8b/10b video and 2b/10b control coding.
//  - Sits between the video timing/packet mux and the 10:1 serialisers.
//  - All lanes share one mode, one pipeline and a fixed latency.
// PARAMETERS
//  NUM_CH   3   number of lanes; lane k uses slice [k*W +: W] of each bus
// PORTS
//  clk       in   1          pixel clock
//  rst       in   1          synchronous reset, active-high
//  mode_in   in   3          0 CTRL, 1 VIDEO, 2 TERC4, 3 VGUARD, 4 DGUARD; 5-7 = CTRL
//  data_in   in   NUM_CH*8   pixel byte per lane (VIDEO)
//  terc4_in  in   NUM_CH*4   nibble per lane (TERC4; also lane 0 in DGUARD)
//  ctrl_in   in   NUM_CH*2   {c1,c0} per lane (CTRL)
//  tmds_out  out  NUM_CH*10  10-bit symbol per lane, bit 0 sent first
// BEHAVIOUR
//  Reset and latency
//  - rst: tmds_out=0, all disparity counters=0, mode pipeline=CTRL.
//  - Latency is exactly 3 clk for every mode.
//  - Inputs sampled at edge N appear on tmds_out after edge N+3.
//  - mode/data/terc4/ctrl are delayed in lockstep; no stalls, no handshake.
//  - A mode switch takes effect on the symbol with the same input timing.
//  VIDEO, per lane (DVI 1.0 algorithm)
//  - Stage 1: n1 = popcount(D).
//  - dec1 = n1>4 | (n1==4 & ~D[0]).
//  - q[0]=D[0]; q[i] = q[i-1]^D[i]^dec1; q[8] = ~dec1.
//  - Stage 2: n = popcount(q[7:0]), 4 bit.
//  - Stage 3: cnt is 5-bit two's complement, range -16..+15, wraps mod 32.
//  - If cnt==0 | n==4:
//      out = {~q8, q8, q[7:0] ^ {8{~q8}}}
//      cnt += q8 ? (2n-8) : (8-2n)
//  - Else if (cnt>0 & n>4) | (cnt<0 & n<4):
//      out = {1, q8, ~q[7:0]}
//      cnt += 2*q8 + 8 - 2n
//  - Else:
//      out = {0, q8, q[7:0]}
//      cnt += -2*~q8 + 2n - 8
//  - cnt is cleared on any output cycle whose mode is not VIDEO.
//  - VIDEO after any other mode therefore starts from cnt=0.
//  CTRL (out[9:0])
//  - 00 -> 1101010100
//  - 01 -> 0010101011
//  - 10 -> 0101010100
//  - 11 -> 1010101011
//  TERC4 nibble -> out[9:0]
//  - 0:1010011100  1:1001100011  2:1011100100  3:1011100010
//  - 4:0101110001  5:0100011110  6:0110001110  7:0100111100
//  - 8:1011001100  9:0100111001  A:0110011100  B:1011000110
//  - C:1010001110  D:1001110001  E:0101100011  F:1011000011
//  Guard bands
//  - VGUARD: lane k%3==1 -> 0100110011; all other lanes -> 1011001100.
//  - DGUARD: lane 0 -> TERC4(terc4_in lane 0); other lanes -> 0100110011.
//  Other rules
//  - Lanes are independent; each lane keeps its own cnt.
//  - rst asserted mid-frame: next edge zeroes all state.
//  - The first 3 symbols after rst release are 0, then CTRL 00 (1101010100)
//    until VIDEO arrives through the pipe.
// TESTING
//  - rst, mode=CTRL, ctrl=00 all lanes -> 3 cycles 0, then every lane 0x354.
//  - mode=VIDEO, data=0x00 twice, from cnt=0 -> 0x100 (cnt=-8), then 0x3FF
//    (cnt=+2). Check latency is exactly 3.
//  - mode=TERC4, nibble sweep 0..F on lane 1 -> table value per cycle, in
//    order, 3 cycles late.
//  - Mode 3 then 4, NUM_CH=3, terc4 lane0=0xC
//    -> VGUARD: 0x2CC, 0x133, 0x2CC
//    -> DGUARD: 0x28E, 0x133, 0x133
//  - Random VIDEO bursts with CTRL gaps vs. reference model. Check:
//    - cnt returns to 0 in each gap
//    - |running disparity| <= 10
//    - decode(encode(D)) == D
//  - rst pulsed mid-VIDEO burst and NUM_CH=4 build -> outputs 0 next cycle,
//    clean restart; lane 3 matches lane 0's coding rules.

Source files
------------

// File: rtl/tmds_multich_encoder.sv
// tmds_multich_encoder
// NUM_CH-lane TMDS symbol encoder for DVI/HDMI transmit. Each lane produces
// 8b/10b video symbols with DC balancing, 2b/10b control symbols, TERC4
// data-island symbols, or video/data-island guard-band symbols. All lanes
// share one mode and one fixed pipeline: stage 0 captures the inputs,
// stage 1 transition-minimises the video byte, stage 2 counts the ones of the
// minimised word, and stage 3 selects the output symbol and updates the
// per-lane running disparity.
//
// Interface timing: there is no valid/ready handshake and no stall. Every
// input sampled at clock edge N (including mode) is reflected on tmds_out
// after edge N+3. Symbols that are not backed by a post-reset sample are
// driven as all-zero.
module tmds_multich_encoder #(
    parameter int NUM_CH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             mode_in,
    input  logic [NUM_CH*8-1:0]    data_in,
    input  logic [NUM_CH*4-1:0]    terc4_in,
    input  logic [NUM_CH*2-1:0]    ctrl_in,
    output logic [NUM_CH*10-1:0]   tmds_out
);

    typedef enum logic [2:0] {
        MODE_CTRL   = 3'd0,
        MODE_VIDEO  = 3'd1,
        MODE_TERC4  = 3'd2,
        MODE_VGUARD = 3'd3,
        MODE_DGUARD = 3'd4
    } mode_e;

    // Guard-band symbols (bit 0 is transmitted first).
    localparam logic [9:0] SYM_GUARD_A = 10'b1011001100;
    localparam logic [9:0] SYM_GUARD_B = 10'b0100110011;

    // ------------------------------------------------------------------
    // Symbol tables and per-lane arithmetic
    // ------------------------------------------------------------------

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] terc4_sym(input logic [3:0] nib);
        logic [9:0] s;
        case (nib)
            4'h0:    s = 10'b1010011100;
            4'h1:    s = 10'b1001100011;
            4'h2:    s = 10'b1011100100;
            4'h3:    s = 10'b1011100010;
            4'h4:    s = 10'b0101110001;
            4'h5:    s = 10'b0100011110;
            4'h6:    s = 10'b0110001110;
            4'h7:    s = 10'b0100111100;
            4'h8:    s = 10'b1011001100;
            4'h9:    s = 10'b0100111001;
            4'hA:    s = 10'b0110011100;
            4'hB:    s = 10'b1011000110;
            4'hC:    s = 10'b1010001110;
            4'hD:    s = 10'b1001110001;
            4'hE:    s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] acc;
        acc = 4'd0;
        for (int i = 0; i < 8; i++) begin
            acc = acc + {3'b000, v[i]};
        end
        return acc;
    endfunction

    // Transition minimisation: XOR chain, or XNOR chain when the byte is
    // ones-heavy (ties broken by bit 0). Bit 8 records which chain was used.
    function automatic logic [8:0] minimise(input logic [7:0] d);
        logic [3:0] n1;
        logic       dec1;
        logic [8:0] q;
        n1   = popcount8(d);
        dec1 = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q    = 9'd0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = q[i-1] ^ d[i] ^ dec1;
        end
        q[8] = ~dec1;
        return q;
    endfunction

    // DC-balancing step: picks whether to invert the minimised byte based on
    // the sign of the running count and the ones-count of the byte, and
    // returns {symbol, next count}. The count is 5-bit two's complement and
    // wraps modulo 32.
    function automatic logic [14:0] video_step(input logic [8:0] qm,
                                               input logic [3:0] n,
                                               input logic [4:0] cnt);
        logic [4:0] n2;
        logic [4:0] cnt_nx;
        logic [9:0] sym;
        logic       q8;
        logic       cnt_pos;
        logic       cnt_neg;
        q8      = qm[8];
        n2      = {n, 1'b0};
        cnt_neg = cnt[4];
        cnt_pos = !cnt[4] && (cnt != 5'd0);
        if ((cnt == 5'd0) || (n == 4'd4)) begin
            sym    = {~q8, q8, qm[7:0] ^ {8{~q8}}};
            cnt_nx = q8 ? (cnt + n2 - 5'd8) : (cnt + 5'd8 - n2);
        end else if ((cnt_pos && (n > 4'd4)) || (cnt_neg && (n < 4'd4))) begin
            sym    = {1'b1, q8, ~qm[7:0]};
            cnt_nx = cnt + {3'b000, q8, 1'b0} + 5'd8 - n2;
        end else begin
            sym    = {1'b0, q8, qm[7:0]};
            cnt_nx = cnt - {3'b000, ~q8, 1'b0} + n2 - 5'd8;
        end
        return {sym, cnt_nx};
    endfunction

    // ------------------------------------------------------------------
    // Stage 0: input capture; out-of-range modes collapse to CTRL
    // ------------------------------------------------------------------
    logic                 s0_vld_d,   s0_vld_q;
    mode_e                s0_mode_d,  s0_mode_q;
    logic [NUM_CH*8-1:0]  s0_data_d,  s0_data_q;
    logic [NUM_CH*4-1:0]  s0_terc4_d, s0_terc4_q;
    logic [NUM_CH*2-1:0]  s0_ctrl_d,  s0_ctrl_q;

    // Normalise mode and forward raw lane data into stage 0.
    always_comb begin
        s0_vld_d   = 1'b1;
        s0_mode_d  = (mode_in > 3'd4) ? MODE_CTRL : mode_e'(mode_in);
        s0_data_d  = data_in;
        s0_terc4_d = terc4_in;
        s0_ctrl_d  = ctrl_in;
    end

    // Stage 0 registers; reset leaves an invalid CTRL bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld_q   <= 1'b0;
            s0_mode_q  <= MODE_CTRL;
            s0_data_q  <= '0;
            s0_terc4_q <= '0;
            s0_ctrl_q  <= '0;
        end else begin
            s0_vld_q   <= s0_vld_d;
            s0_mode_q  <= s0_mode_d;
            s0_data_q  <= s0_data_d;
            s0_terc4_q <= s0_terc4_d;
            s0_ctrl_q  <= s0_ctrl_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: transition-minimised 9-bit word per lane
    // ------------------------------------------------------------------
    logic                 s1_vld_d,   s1_vld_q;
    mode_e                s1_mode_d,  s1_mode_q;
    logic [NUM_CH*9-1:0]  s1_qm_d,    s1_qm_q;
    logic [NUM_CH*4-1:0]  s1_terc4_d, s1_terc4_q;
    logic [NUM_CH*2-1:0]  s1_ctrl_d,  s1_ctrl_q;

    // Minimise every lane's byte; side-band fields move along unchanged.
    always_comb begin
        s1_vld_d   = s0_vld_q;
        s1_mode_d  = s0_mode_q;
        s1_terc4_d = s0_terc4_q;
        s1_ctrl_d  = s0_ctrl_q;
        s1_qm_d    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            s1_qm_d[k*9 +: 9] = minimise(s0_data_q[k*8 +: 8]);
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_mode_q  <= MODE_CTRL;
            s1_qm_q    <= '0;
            s1_terc4_q <= '0;
            s1_ctrl_q  <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_mode_q  <= s1_mode_d;
            s1_qm_q    <= s1_qm_d;
            s1_terc4_q <= s1_terc4_d;
            s1_ctrl_q  <= s1_ctrl_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: ones count of the minimised byte per lane
    // ------------------------------------------------------------------
    logic                 s2_vld_d,   s2_vld_q;
    mode_e                s2_mode_d,  s2_mode_q;
    logic [NUM_CH*9-1:0]  s2_qm_d,    s2_qm_q;
    logic [NUM_CH*4-1:0]  s2_n_d,     s2_n_q;
    logic [NUM_CH*4-1:0]  s2_terc4_d, s2_terc4_q;
    logic [NUM_CH*2-1:0]  s2_ctrl_d,  s2_ctrl_q;

    // Count ones of q[7:0] so stage 3 only has to compare and add.
    always_comb begin
        s2_vld_d   = s1_vld_q;
        s2_mode_d  = s1_mode_q;
        s2_qm_d    = s1_qm_q;
        s2_terc4_d = s1_terc4_q;
        s2_ctrl_d  = s1_ctrl_q;
        s2_n_d     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            s2_n_d[k*4 +: 4] = popcount8(s1_qm_q[k*9 +: 8]);
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_q   <= 1'b0;
            s2_mode_q  <= MODE_CTRL;
            s2_qm_q    <= '0;
            s2_n_q     <= '0;
            s2_terc4_q <= '0;
            s2_ctrl_q  <= '0;
        end else begin
            s2_vld_q   <= s2_vld_d;
            s2_mode_q  <= s2_mode_d;
            s2_qm_q    <= s2_qm_d;
            s2_n_q     <= s2_n_d;
            s2_terc4_q <= s2_terc4_d;
            s2_ctrl_q  <= s2_ctrl_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: symbol selection and running disparity
    // ------------------------------------------------------------------
    logic [NUM_CH*10-1:0] tmds_d, tmds_q;
    logic [NUM_CH*5-1:0]  cnt_d,  cnt_q;

    // Pick each lane's symbol for the current mode. The disparity count only
    // survives back-to-back VIDEO symbols; any other symbol (including the
    // zero symbols of an unfilled pipeline) clears it.
    always_comb begin
        tmds_d = '0;
        cnt_d  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (s2_vld_q) begin
                case (s2_mode_q)
                    MODE_VIDEO: begin
                        {tmds_d[k*10 +: 10], cnt_d[k*5 +: 5]} =
                            video_step(s2_qm_q[k*9 +: 9], s2_n_q[k*4 +: 4],
                                       cnt_q[k*5 +: 5]);
                    end
                    MODE_TERC4: begin
                        tmds_d[k*10 +: 10] = terc4_sym(s2_terc4_q[k*4 +: 4]);
                    end
                    MODE_VGUARD: begin
                        tmds_d[k*10 +: 10] = ((k % 3) == 1) ? SYM_GUARD_B
                                                            : SYM_GUARD_A;
                    end
                    MODE_DGUARD: begin
                        tmds_d[k*10 +: 10] = (k == 0) ? terc4_sym(s2_terc4_q[3:0])
                                                      : SYM_GUARD_B;
                    end
                    default: begin
                        tmds_d[k*10 +: 10] = ctrl_sym(s2_ctrl_q[k*2 +: 2]);
                    end
                endcase
            end
        end
    end

    // Output symbol and disparity registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmds_q <= '0;
            cnt_q  <= '0;
        end else begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds_out = tmds_q;

endmodule

// File: tb/tb_tmds_multich_encoder.sv
// tb_tmds_multich_encoder
// Drives a 4-lane and a 3-lane encoder from the same stimulus. The driver
// predicts, for every clock edge, the symbols that edge must produce and
// pushes them into exp_q; the monitor pops one entry per cycle and compares.
module tb_tmds_multich_encoder;

    localparam int NL = 4;

    localparam logic [9:0] TERC_TAB [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
    localparam logic [9:0] CTRL_TAB [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    logic               clk = 1'b0;
    logic               rst;
    logic [2:0]         mode_in;
    logic [NL*8-1:0]    data_in;
    logic [NL*4-1:0]    terc4_in;
    logic [NL*2-1:0]    ctrl_in;
    logic [NL*10-1:0]   tmds4;
    logic [29:0]        tmds3;

    int n_checks = 0;
    int n_fail   = 0;

    // {rst, mode[2:0], data[31:0], terc4[15:0], ctrl[7:0]} of recent edges
    logic [59:0] hist_q[$];
    // {is_video, data[31:0], symbols[39:0]} expected after each edge
    logic [72:0] exp_q[$];
    int          mcnt [NL];

    // ------------------------------------------------------------------
    // Clock and DUTs
    // ------------------------------------------------------------------
    always #5 clk = ~clk;

    tmds_multich_encoder #(.NUM_CH(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .mode_in  (mode_in),
        .data_in  (data_in),
        .terc4_in (terc4_in),
        .ctrl_in  (ctrl_in),
        .tmds_out (tmds4)
    );

    tmds_multich_encoder #(.NUM_CH(3)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .mode_in  (mode_in),
        .data_in  (data_in[23:0]),
        .terc4_in (terc4_in[11:0]),
        .ctrl_in  (ctrl_in[5:0]),
        .tmds_out (tmds3)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------

    // DVI video symbol for byte d given running disparity cnt (in symbols'
    // ones-minus-zeros, which is what the 5-bit counter tracks).
    function automatic logic [9:0] video_sym(input logic [7:0] d, input int cnt);
        int         n1;
        int         n;
        bit         use_xnor;
        bit         inv;
        logic [8:0] q;
        n1       = $countones(d);
        use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = !use_xnor;
        n    = $countones(q[7:0]);
        if (cnt == 0 || n == 4) inv = !q[8];
        else                    inv = (cnt > 0 && n > 4) || (cnt < 0 && n < 4);
        return {inv, q[8], inv ? ~q[7:0] : q[7:0]};
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] w;
        logic [7:0] d;
        w    = s[9] ? ~s[7:0] : s[7:0];
        d    = '0;
        d[0] = w[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = s[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
        end
        return d;
    endfunction

    // Expected output after the edge just driven: the stimulus of three
    // edges earlier, unless reset was sampled at any edge in that window.
    task automatic predict();
        logic [59:0] old;
        logic [2:0]  m;
        logic [31:0] d;
        logic [15:0] t;
        logic [7:0]  c;
        logic [39:0] sym;
        logic [9:0]  s;
        bit          zero;
        zero = (hist_q.size() < 4);
        foreach (hist_q[i]) if (hist_q[i][59]) zero = 1'b1;
        if (zero) begin
            for (int k = 0; k < NL; k++) mcnt[k] = 0;
            exp_q.push_back(73'd0);
            return;
        end
        old = hist_q[0];
        m   = old[58:56];
        d   = old[55:24];
        t   = old[23:8];
        c   = old[7:0];
        if (m > 3'd4) m = 3'd0;
        sym = '0;
        for (int k = 0; k < NL; k++) begin
            case (m)
                3'd1:    s = video_sym(d[k*8 +: 8], mcnt[k]);
                3'd2:    s = TERC_TAB[t[k*4 +: 4]];
                3'd3:    s = ((k % 3) == 1) ? 10'h133 : 10'h2CC;
                3'd4:    s = (k == 0) ? TERC_TAB[t[3:0]] : 10'h133;
                default: s = CTRL_TAB[c[k*2 +: 2]];
            endcase
            sym[k*10 +: 10] = s;
            if (m == 3'd1) mcnt[k] = mcnt[k] + 2 * $countones(s) - 10;
            else           mcnt[k] = 0;
        end
        exp_q.push_back({(m == 3'd1), d, sym});
    endtask

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic drive(input logic r, input logic [2:0] m, input logic [31:0] d,
                         input logic [15:0] t, input logic [7:0] c);
        rst      = r;
        mode_in  = m;
        data_in  = d;
        terc4_in = t;
        ctrl_in  = c;
        hist_q.push_back({r, m, d, t, c});
        if (hist_q.size() > 4) void'(hist_q.pop_front());
        predict();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        logic [72:0] e;
        int          rd [NL];
        int          ones;
        for (int k = 0; k < NL; k++) rd[k] = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tmds_4lane", 64'(tmds4), 64'(e[39:0]));
                check("tmds_3lane", 64'(tmds3), 64'(e[29:0]));
                for (int k = 0; k < NL; k++) begin
                    if (e[72]) begin
                        check("decode", 64'(decode(tmds4[k*10 +: 10])), 64'(e[40 + k*8 +: 8]));
                        ones  = $countones(tmds4[k*10 +: 10]);
                        rd[k] = rd[k] + 2 * ones - 10;
                        n_checks++;
                        if (rd[k] > 10 || rd[k] < -10) begin
                            n_fail++;
                            $display("FAIL disparity lane %0d: got %0d required within +/-10", k, rd[k]);
                        end
                    end else begin
                        rd[k] = 0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] r32;
        logic [31:0] r2;
        logic [31:0] d;
        logic [15:0] t;
        logic [2:0]  m;
        int          len;
        int          gap;
        int          wait_cyc;

        for (int k = 0; k < NL; k++) mcnt[k] = 0;

        // Reset, then CTRL 00: three zero symbols followed by 0x354.
        repeat (3) drive(1'b1, 3'd0, 32'd0, 16'd0, 8'd0);
        repeat (6) drive(1'b0, 3'd0, 32'd0, 16'd0, 8'd0);

        // Two zero bytes from cnt=0, then every control code on the lanes.
        drive(1'b0, 3'd1, 32'd0, 16'd0, 8'd0);
        drive(1'b0, 3'd1, 32'd0, 16'd0, 8'd0);
        repeat (2) drive(1'b0, 3'd0, 32'd0, 16'd0, 8'hE4);

        // TERC4 sweep; lane 1 walks 0..F.
        for (int i = 0; i < 16; i++) begin
            t = '0;
            for (int k = 0; k < NL; k++) t[k*4 +: 4] = 4'((i + k - 1) & 15);
            r32 = $urandom;
            drive(1'b0, 3'd2, r32, t, 8'd0);
        end

        // Video guard then data-island guard with lane 0 nibble C.
        r32 = $urandom;
        drive(1'b0, 3'd3, r32, r32[15:0], r32[7:0]);
        r32 = $urandom;
        drive(1'b0, 3'd4, r32, {r32[15:4], 4'hC}, r32[7:0]);
        drive(1'b0, 3'd0, 32'd0, 16'd0, 8'd0);

        // Random video bursts separated by non-video gaps.
        for (int b = 0; b < 30; b++) begin
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) begin
                r32 = $urandom;
                r2  = $urandom;
                case (b % 3)
                    0:       d = r32 & 32'h0F0F_1F03;
                    1:       d = r32 | 32'hF0F0_E0FC;
                    default: d = r32;
                endcase
                drive(1'b0, 3'd1, d, r2[15:0], r2[23:16]);
            end
            gap = $urandom_range(1, 4);
            for (int i = 0; i < gap; i++) begin
                r32 = $urandom;
                m   = 3'($urandom_range(0, 7));
                if (m == 3'd1) m = 3'd0;
                drive(1'b0, m, r32, r32[31:16], r32[7:0]);
            end
        end

        // Reset pulsed in the middle of a video burst.
        for (int i = 0; i < 20; i++) begin
            r32 = $urandom;
            drive((i == 8), 3'd1, r32, 16'd0, 8'd0);
        end
        repeat (5) drive(1'b0, 3'd0, 32'd0, 16'd0, 8'd0);

        // Let the monitor consume what is still queued.
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_checks++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
